// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Latency: none; declarations only.
// Backpressure: not applicable.
package uart_pkg;

    localparam int ENTRY_W    = 10;
    localparam int DEF_DEPTH  = 8;
    localparam int DEF_THRESH = 4;

    // One received frame as it sits in the Rx FIFO.
    typedef struct packed {
        logic       frm_err;
        logic       par_err;
        logic [7:0] data;
    } rx_entry;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Frame storage for the Rx FIFO: DEPTH x rx_entry array.
// Latency: write lands on the clock edge; read is combinational from raddr.
// Backpressure: none; the caller only asserts we when a slot is free.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rx_entry       wdata,
    input  logic [AW-1:0] raddr,
    output rx_entry       rdata
);

    rx_entry mem [DEPTH];

    // Store the incoming frame; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Rx frame FIFO, first-word-fall-through, with overrun/threshold/parity-error status.
// Latency: a frame pushed into an empty FIFO is visible on rd_* right after that edge.
// Backpressure: rd_ready stalls the head; writes while full (no pop) are dropped and flag overrun.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int THRESH = DEF_THRESH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     wr_par_err,
    input  logic                     wr_frm_err,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_par_err,
    output logic                     rd_frm_err,
    input  logic                     flush,
    input  logic                     overrun_clr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overrun,
    output logic                     thresh_irq,
    output logic [7:0]               par_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_req;
    logic          push_req;
    logic          do_push;
    logic          do_pop;
    logic          drop;
    rx_entry       wr_entry;
    rx_entry       head;

    // Status is decoded straight from the registered count.
    assign empty      = (count == '0);
    assign full       = (count == CW'(DEPTH));
    assign rd_valid   = ~empty;
    assign thresh_irq = (count >= CW'(THRESH));

    // A pop frees a slot on the same edge, so a write into a full FIFO is still taken then.
    assign pop_req  = rd_valid & rd_ready;
    assign push_req = wr_en & (~full | pop_req);
    // Flush wins over both directions; a frame arriving with flush is ignored, not counted as a drop.
    assign do_pop   = pop_req & ~flush;
    assign do_push  = push_req & ~flush;
    assign drop     = wr_en & full & ~pop_req & ~flush;

    assign wr_entry = '{frm_err: wr_frm_err, par_err: wr_par_err, data: wr_data};

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock (clock),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign rd_data    = head.data;
    assign rd_par_err = head.par_err;
    assign rd_frm_err = head.frm_err;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overrun; a drop on the same edge as a clear keeps it set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

    // Saturating count of accepted frames that carried a parity error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            par_err_cnt <= '0;
        end else if (do_push && wr_par_err && (par_err_cnt != 8'hFF)) begin
            par_err_cnt <= par_err_cnt + 1'b1;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of frame entries; SHALL be a power of two, at least 2.
REQ-002 Parameter THRESH, default 4, fill level at which thresh_irq asserts; range 1..DEPTH.
REQ-003 clock  input  1  Rx clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  single-cycle pulse from the Rx datapath: one received frame is present.
REQ-006 wr_data  input  8  received byte, valid when wr_en=1.
REQ-007 wr_par_err  input  1  parity mismatch for this frame, valid when wr_en=1.
REQ-008 wr_frm_err  input  1  stop-bit (framing) error for this frame, valid when wr_en=1.
REQ-009 rd_valid  output  1  head entry available.
REQ-010 rd_ready  input  1  consumer accepts the head entry.
REQ-011 rd_data  output  8  head entry byte.
REQ-012 rd_par_err  output  1  head entry parity flag.
REQ-013 rd_frm_err  output  1  head entry framing flag.
REQ-014 flush  input  1  synchronous clear of all entries.
REQ-015 overrun_clr  input  1  clears the overrun flag.
REQ-016 count  output  clog2(DEPTH)+1  current number of stored entries.
REQ-017 full / empty  output  1 each  count==DEPTH / count==0.
REQ-018 overrun  output  1  sticky flag: a frame was dropped.
REQ-019 thresh_irq  output  1  count>=THRESH.
REQ-020 par_err_cnt  output  8  saturating count of accepted frames with wr_par_err=1.

Function
REQ-021 Each entry SHALL store {frm_err, par_err, data[7:0]} (10 bits).
REQ-022 The block SHALL be first-word-fall-through:
- rd_data/rd_par_err/rd_frm_err SHALL reflect the entry at the read pointer whenever rd_valid=1.
- rd_valid SHALL equal !empty.
REQ-023 Pop SHALL occur on a clock edge where rd_valid=1 and rd_ready=1; the read pointer advances by 1 modulo DEPTH.
REQ-024 Push SHALL occur on a clock edge where wr_en=1 and either full=0 or a pop occurs on the same edge; the write pointer advances by 1 modulo DEPTH.
REQ-025 Latency: a frame pushed at edge N SHALL produce rd_valid=1 after edge N when the FIFO was empty; no same-cycle write-to-read bypass.
REQ-026 Count update per edge: push only +1, pop only -1, push and pop 0, neither 0.
REQ-027 wr_en=1 while full=1 with no same-edge pop SHALL drop the frame; overrun=1 after that edge; count, pointers and memory SHALL be unchanged.
REQ-028 overrun SHALL clear on an edge with overrun_clr=1, unless a drop occurs on the same edge, in which case overrun SHALL stay 1.
REQ-029 flush=1 SHALL set pointers and count to 0 on that edge; push and pop on the same edge SHALL be ignored; overrun and par_err_cnt SHALL be unaffected.
REQ-030 par_err_cnt SHALL increment only on an accepted push with wr_par_err=1, and SHALL saturate at 255; dropped frames SHALL NOT be counted.
REQ-031 full, empty and thresh_irq SHALL be decoded from the registered count with no extra cycle of delay.

Reset
REQ-032 On reset: pointers=0, count=0, empty=1, full=0, rd_valid=0, overrun=0, thresh_irq=0, par_err_cnt=0.
REQ-033 Memory contents SHALL NOT require reset; rd_data is don't-care while rd_valid=0.
REQ-034 Reset asserted mid-operation SHALL discard all stored frames immediately.

Structure
REQ-035 Shared package uart_pkg SHALL hold:
- the entry width constant (10);
- the rx_entry typedef {frm_err, par_err, data};
- default DEPTH and THRESH constants.
REQ-036 Storage SHALL be a sub-module uart_rx_fifo_mem: DEPTH x 10 array, registered write, asynchronous read.

Verification
REQ-037 Push 0x41, 0x42, 0x43 (no errors), rd_ready=0 -> count=3, rd_data=0x41; then rd_ready=1 for 3 cycles -> bytes read 0x41, 0x42, 0x43 in order, empty=1.
REQ-038 Push 9 frames into DEPTH=8 with rd_ready=0 -> full=1 after the 8th, overrun=1 after the 9th, count=8, 9th byte absent on readout.
REQ-039 Full FIFO, wr_en=1 and rd_ready=1 on the same edge -> count stays 8, overrun stays 0, new byte read out last.
REQ-040 Push 4 frames, then assert flush and wr_en together -> count=0, empty=1; next push 0x55 -> rd_data=0x55.
REQ-041 Push 3 frames with wr_par_err=1 and 1 with wr_frm_err=1 -> par_err_cnt=3, thresh_irq=1 at count=4, rd_frm_err=1 on the 4th entry.
REQ-042 Overrun and overrun_clr on the same edge -> overrun=1; overrun_clr alone on a later edge -> overrun=0.
